// File: rtl/clkgen_pkg.sv
// rtl/clkgen_pkg.sv - shared state encoding and constants for the PLL lock supervisor
package clkgen_pkg;

  typedef enum logic [2:0] {
    RESET,
    WAIT_LOCK,
    SETTLE,
    RUN,
    FAULT
  } pll_sup_state_t;

  localparam int LOSS_COUNT_WIDTH = 16;

endpackage

// File: rtl/pll_lock_channel.sv
// rtl/pll_lock_channel.sv - one PLL: lock synchroniser, reset/settle/retry FSM, optional loss counter
// Optional loss counter built only when PLL_SUPERVISOR_LOSS_COUNT_EN is defined.
module pll_lock_channel
  import clkgen_pkg::*;
#(
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int SETTLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pll_lock,
  input  logic                        retry_clear,
  output logic                        pll_reset,
  output logic                        clk_en,
  output logic                        fault,
  output logic [LOSS_COUNT_WIDTH-1:0] loss_count
);

  localparam int MAX_AB  = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CYC = (MAX_AB > SETTLE_CYCLES) ? MAX_AB : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

  (* ASYNC_REG = "TRUE" *) logic lock_meta;
  (* ASYNC_REG = "TRUE" *) logic lock_s;

  pll_sup_state_t   state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [3:0]       retries, retries_d;
  logic             pll_reset_d, clk_en_d, fault_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
      state     <= RESET;
      cnt       <= '0;
      retries   <= '0;
      pll_reset <= 1'b1;
      clk_en    <= 1'b0;
      fault     <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
      state     <= state_d;
      cnt       <= cnt_d;
      retries   <= retries_d;
      pll_reset <= pll_reset_d;
      clk_en    <= clk_en_d;
      fault     <= fault_d;
    end
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    retries_d   = retries;
    pll_reset_d = pll_reset;
    clk_en_d    = clk_en;
    fault_d     = fault;
    case (state)
      RESET: begin
        pll_reset_d = 1'b1;
        clk_en_d    = 1'b0;
        fault_d     = 1'b0;
        if (cnt == RESET_LAST) begin
          state_d     = WAIT_LOCK;
          cnt_d       = '0;
          pll_reset_d = 1'b0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      WAIT_LOCK: begin
        pll_reset_d = 1'b0;
        if (lock_s) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          cnt_d       = '0;
          pll_reset_d = 1'b1;
          if (retries < RETRY_LIMIT) begin
            retries_d = retries + 1'b1;
            state_d   = RESET;
          end else begin
            state_d = FAULT;
            fault_d = 1'b1;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      SETTLE: begin
        // A lock drop here is a glitch: restart the wait without spending a retry.
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt == SETTLE_LAST) begin
          state_d  = RUN;
          cnt_d    = '0;
          clk_en_d = 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      RUN: begin
        clk_en_d = 1'b1;
        if (!lock_s) begin
          clk_en_d    = 1'b0;
          pll_reset_d = 1'b1;
          retries_d   = '0;
          cnt_d       = '0;
          state_d     = RESET;
        end
      end
      FAULT: begin
        pll_reset_d = 1'b1;
        clk_en_d    = 1'b0;
        fault_d     = 1'b1;
        if (retry_clear) begin
          state_d   = RESET;
          retries_d = '0;
          cnt_d     = '0;
          fault_d   = 1'b0;
        end
      end
      default: begin
        state_d     = RESET;
        cnt_d       = '0;
        pll_reset_d = 1'b1;
        clk_en_d    = 1'b0;
        fault_d     = 1'b0;
      end
    endcase
  end

`ifdef PLL_SUPERVISOR_LOSS_COUNT_EN
  logic [LOSS_COUNT_WIDTH-1:0] loss_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      loss_q <= '0;
    end else if (state == RUN && !lock_s && loss_q != '1) begin
      loss_q <= loss_q + 1'b1;
    end
  end

  assign loss_count = loss_q;
`else
  assign loss_count = '0;
`endif

endmodule

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - supervises NUM_PLLS independent PLL lock channels and gates their BUFGCEs
// Optional per-channel loss counters enabled by PLL_SUPERVISOR_LOSS_COUNT_EN.
module pll_lock_supervisor
  import clkgen_pkg::*;
#(
  parameter int NUM_PLLS      = 2,
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int SETTLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_PLLS-1:0]                  pll_lock,
  output logic [NUM_PLLS-1:0]                  pll_reset,
  output logic [NUM_PLLS-1:0]                  clk_en,
  output logic                                 all_ready,
  output logic [NUM_PLLS-1:0]                  fault,
  input  logic                                 retry_clear,
  output logic [NUM_PLLS*LOSS_COUNT_WIDTH-1:0] loss_count
);

  for (genvar i = 0; i < NUM_PLLS; i++) begin : g_ch
    pll_lock_channel #(
      .RESET_CYCLES (RESET_CYCLES),
      .LOCK_TIMEOUT (LOCK_TIMEOUT),
      .SETTLE_CYCLES(SETTLE_CYCLES),
      .MAX_RETRIES  (MAX_RETRIES)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .pll_lock   (pll_lock[i]),
      .retry_clear(retry_clear),
      .pll_reset  (pll_reset[i]),
      .clk_en     (clk_en[i]),
      .fault      (fault[i]),
      .loss_count (loss_count[i*LOSS_COUNT_WIDTH +: LOSS_COUNT_WIDTH])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      all_ready <= 1'b0;
    end else begin
      all_ready <= &clk_en;
    end
  end

endmodule
